alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the 4-bit ALU. Accepts instructions over a valid/ready link and reads operands from a local
//  register file. Drives A/B/SEL to the ALU for one cycle, then writes the ALU result back to the destination register.
//  Presents the result on a valid/ready output. Fully serialised: one instruction in flight, 3 cycles minimum per op.
// PARAMETERS
//  DATA_W  4   operand/result width; must equal the ALU width
//  REG_N   4   number of registers in the local register file
//  REG_AW  2   register index width, = clog2(REG_N)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  in_valid    in   1         instruction valid
//  in_ready    out  1         instruction accepted when in_valid & in_ready
//  in_instr    in   3+3*REG_AW  {op[2:0], rd, rs1, rs2} (9 bits at defaults)
//  alu_a       out  DATA_W    to ALU A
//  alu_b       out  DATA_W    to ALU B
//  alu_sel     out  3         to ALU SEL
//  alu_result  in   DATA_W    from ALU RESULT (combinational from alu_a/alu_b/alu_sel)
//  out_valid   out  1         result valid
//  out_ready   in   1         consumer ready
//  out_data    out  DATA_W    written-back value (0 on error)
//  out_rd      out  REG_AW    destination index of the completed op
//  out_zero    out  1         out_data == 0 and out_err == 0
//  out_err     out  1         op was illegal; no register written
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE. All registers, alu_a/alu_b/alu_sel, out_* = 0. in_ready = 0 while rst_n = 0.
//  - Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT (A only; B driven 0).
//    111 LDI: rd <= imm = {rs1,rs2}, zero-extended or truncated to DATA_W; alu_sel driven 111.
//    101 and 110 are illegal.
//  - FSM IDLE -> EXEC -> WB -> IDLE.
//    IDLE: in_ready = 1. On accept, latch op/rd, read rs1/rs2 from the register file, go to EXEC.
//    EXEC (1 cycle): alu_a/alu_b/alu_sel hold registered operands.
//      On the exiting edge, capture alu_result (or imm for LDI) into out_data and write reg[rd]. Go to WB.
//      Illegal op: out_err = 1, out_data = 0, no write.
//    WB: out_valid = 1, with out_data/out_rd/out_zero/out_err stable until out_valid & out_ready.
//      Handshake edge -> IDLE; out_valid drops the next cycle. in_ready = 0 in EXEC and WB.
//  - Latency: accept edge N -> out_valid high from cycle N+2. Peak throughput is 1 op per 3 cycles with out_ready tied high.
//  - Operand read happens at accept, after the previous writeback edge. Back-to-back dependent ops therefore see the
//    updated value; no forwarding is required.
//  - Arithmetic is mod 2^DATA_W: carry and borrow are discarded (ALU behaviour); SUB wraps.
//  - rd == rs1 == rs2 is legal; the operands are the pre-write values.
//  - alu_a/alu_b/alu_sel hold their last value outside EXEC (no glitching to the ALU).
//  - Reset mid-EXEC or mid-WB aborts the op. No writeback, no out_valid, register file cleared.
// STRUCTURE
//  - Package alu_pkg: OP_ADD..OP_NOT and OP_LDI localparams, state encoding (IDLE/EXEC/WB), instruction field offsets.
//    The ALU shares the opcode constants.
//  - Sub-module alu_regfile: REG_N x DATA_W, 2 async read ports, 1 sync write port, async clear on rst_n.
//  - The ALU itself is instantiated by the parent beside this block, not inside it.
// TESTING
//  1 Reset: rst_n = 0 -> in_ready = 0, out_valid = 0, alu_* = 0. Release -> in_ready = 1. Reading all regs through ops gives 0.
//  2 LDI r1 = 9 (111_01_10_01), LDI r2 = 5, ADD r3 = r1 + r2 (000_11_01_10)
//    -> third result: out_data = 0xE, out_rd = 3, out_zero = 0. out_valid exactly 2 cycles after each accept.
//  3 SUB r0 = r2 - r1 -> out_data = 0xC (wrap). SUB r0 = r1 - r1 -> out_data = 0, out_zero = 1.
//    NOT r0 = ~r1 -> 0x6, alu_b = 0.
//  4 Backpressure: out_ready = 0 for 5 cycles in WB -> out_valid, out_data and out_rd stable; in_ready = 0.
//    Next instruction is not accepted until after the handshake.
//  5 Illegal op 101, rd = 2 -> out_err = 1, out_data = 0, out_zero = 0. A following ADD reading r2 shows r2 unchanged.
//  6 rst_n pulsed low during EXEC of ADD r3 -> no out_valid, r3 reads 0. The next instruction is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU and its issue stage: opcodes, issue FSM
// state encoding and instruction field layout.
package alu_pkg;

  // Default datapath geometry; the ALU width must match ALU_DATA_W.
  localparam int ALU_DATA_W = 4;
  localparam int ALU_REG_N  = 4;
  localparam int ALU_REG_AW = 2;

  // Opcodes, shared with the ALU SEL decode. 101 and 110 are unassigned.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b111;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_e;

  // Instruction layout {op[2:0], rd, rs1, rs2}; offsets depend on index width.
  function automatic int fld_op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int fld_rd_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int fld_rs1_lsb(input int aw);
    return aw;
  endfunction

  // True for every opcode the ALU implements (LDI bypasses the ALU result).
  function automatic logic op_is_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LDI: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Local register file: two asynchronous read ports, one synchronous write
// port, whole array cleared by the asynchronous reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_N  = ALU_REG_N,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  output logic [DATA_W-1:0] o_rd_data_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [REG_N];

  assign o_rd_data_a = r_mem[i_rd_addr_a];
  assign o_rd_data_b = r_mem[i_rd_addr_b];

  // Storage: cleared on reset, one write per cycle otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serialised issue stage for the 4-bit ALU: accepts one instruction, reads
// operands, drives the ALU for one cycle, writes back and presents the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_N  = ALU_REG_N,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3+3*REG_AW-1:0] in_instr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_sel,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_zero,
  output logic                  out_err
);

  localparam int OP_LSB  = fld_op_lsb(REG_AW);
  localparam int RD_LSB  = fld_rd_lsb(REG_AW);
  localparam int RS1_LSB = fld_rs1_lsb(REG_AW);

  issue_state_e      r_state, w_state_nxt;
  logic              r_in_ready, r_out_valid;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_alu_a, r_alu_b;
  logic [2:0]        r_alu_sel;
  logic [DATA_W-1:0] r_out_data;
  logic [REG_AW-1:0] r_out_rd;
  logic              r_out_zero, r_out_err;

  logic [2:0]        w_op;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_b_sel, w_imm;
  logic              w_accept, w_err, w_wr_en, w_wb_zero;
  logic [DATA_W-1:0] w_wb_data;

  assign w_op  = in_instr[OP_LSB +: 3];
  assign w_rd  = in_instr[RD_LSB +: REG_AW];
  assign w_rs1 = in_instr[RS1_LSB +: REG_AW];
  assign w_rs2 = in_instr[0 +: REG_AW];
  // Immediate is {rs1,rs2}, resized to the datapath width.
  assign w_imm = DATA_W'({w_rs1, w_rs2});

  assign w_accept = in_valid & r_in_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;
  assign out_zero  = r_out_zero;
  assign out_err   = r_out_err;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr_a (w_rs1),
    .o_rd_data_a (w_rf_a),
    .i_rd_addr_b (w_rs2),
    .o_rd_data_b (w_rf_b),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (r_rd),
    .i_wr_data   (w_wb_data)
  );

  // NOT is unary, so the B operand is forced to zero for it.
  always_comb begin
    w_b_sel = w_rf_b;
    if (w_op == OP_NOT) begin
      w_b_sel = '0;
    end else begin
      w_b_sel = w_rf_b;
    end
  end

  // Writeback value: zero on an illegal op, the immediate for LDI, else the ALU result.
  always_comb begin
    w_err     = ~op_is_legal(r_op);
    w_wb_data = '0;
    if (w_err) begin
      w_wb_data = '0;
    end else if (r_op == OP_LDI) begin
      w_wb_data = r_imm;
    end else begin
      w_wb_data = alu_result;
    end
    w_wr_en   = (r_state == ST_EXEC) && !w_err;
    w_wb_zero = !w_err && (w_wb_data == '0);
  end

  // Next-state logic for IDLE -> EXEC -> WB -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, handshake flags, ALU drive and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_op        <= 3'b000;
      r_rd        <= '0;
      r_imm       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 3'b000;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_zero  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_WB);
      // Operands are captured at accept and held until the next accept.
      if (w_accept) begin
        r_op      <= w_op;
        r_rd      <= w_rd;
        r_imm     <= w_imm;
        r_alu_a   <= w_rf_a;
        r_alu_b   <= w_b_sel;
        r_alu_sel <= w_op;
      end
      // Result is captured on the edge leaving EXEC and held through WB.
      if (r_state == ST_EXEC) begin
        r_out_data <= w_wb_data;
        r_out_rd   <= r_rd;
        r_out_zero <= w_wb_zero;
        r_out_err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU beside it.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_rd;
  logic       out_zero;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] ex_a, ex_b;
  logic [2:0] ex_sel;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit ALU driven by the issue stage.
  always_comb begin
    alu_result = 4'h0;
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      default: alu_result = 4'h0;
    endcase
  end

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction from a negedge, wait for accept, then for out_valid.
  task automatic send(input string tag, input logic [8:0] instr);
    int k;
    int edges;
    in_instr = instr;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_accept"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    ex_a = alu_a;
    ex_b = alu_b;
    ex_sel = alu_sel;
    while (!out_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, edges, 2);
  endtask

  // Check the presented result, complete the handshake, confirm out_valid drops.
  task automatic finish(input string tag, input logic [3:0] d, input logic [1:0] rd,
                        input logic z, input logic e);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_rd"}, out_rd, rd);
    chk({tag, "_zero"}, out_zero, z);
    chk({tag, "_err"}, out_err, e);
    chk({tag, "_inrdy_wb"}, in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vdrop"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_instr = 9'h000;
    out_ready = 1'b1;
    #3 rst_n = 1'b0;

    // 1: reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    send("rd01", mk(3'b000, 2'd0, 2'd0, 2'd1));
    finish("rd01", 4'h0, 2'd0, 1'b1, 1'b0);
    send("rd23", mk(3'b000, 2'd1, 2'd2, 2'd3));
    finish("rd23", 4'h0, 2'd1, 1'b1, 1'b0);

    // 2: LDI r1=9, LDI r2=5, ADD r3=r1+r2
    send("ldi1", mk(3'b111, 2'd1, 2'd2, 2'd1));
    chk("ldi1_sel", ex_sel, 3'b111);
    finish("ldi1", 4'h9, 2'd1, 1'b0, 1'b0);
    send("ldi2", mk(3'b111, 2'd2, 2'd1, 2'd1));
    finish("ldi2", 4'h5, 2'd2, 1'b0, 1'b0);
    send("add3", mk(3'b000, 2'd3, 2'd1, 2'd2));
    chk("add3_alu_a", ex_a, 4'h9);
    chk("add3_alu_b", ex_b, 4'h5);
    finish("add3", 4'hE, 2'd3, 1'b0, 1'b0);

    // 3: SUB wrap, SUB to zero, NOT
    send("subw", mk(3'b001, 2'd0, 2'd2, 2'd1));
    finish("subw", 4'hC, 2'd0, 1'b0, 1'b0);
    send("subz", mk(3'b001, 2'd0, 2'd1, 2'd1));
    finish("subz", 4'h0, 2'd0, 1'b1, 1'b0);
    send("not", mk(3'b100, 2'd0, 2'd1, 2'd2));
    chk("not_alu_b", ex_b, 4'h0);
    chk("not_alu_sel", ex_sel, 3'b100);
    finish("not", 4'h6, 2'd0, 1'b0, 1'b0);

    // 4: backpressure on ADD r3=r1+r1 (9+9 wraps to 2), LDI r0=3 waiting
    out_ready = 1'b0;
    send("bp", mk(3'b000, 2'd3, 2'd1, 2'd1));
    in_instr = mk(3'b111, 2'd0, 2'd0, 2'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 4'h2);
      chk("bp_rd", out_rd, 2'd3);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    finish("bp", 4'h2, 2'd3, 1'b0, 1'b0);
    send("ldi0", mk(3'b111, 2'd0, 2'd0, 2'd3));
    finish("ldi0", 4'h3, 2'd0, 1'b0, 1'b0);

    // 5: illegal op, then r2 unchanged (rd == rs1 == rs2 uses pre-write value)
    send("ill", mk(3'b101, 2'd2, 2'd1, 2'd1));
    finish("ill", 4'h0, 2'd2, 1'b0, 1'b1);
    send("r2chk", mk(3'b000, 2'd2, 2'd2, 2'd2));
    finish("r2chk", 4'hA, 2'd2, 1'b0, 1'b0);

    // 6: reset during EXEC of ADD r3=r1+r2
    in_instr = mk(3'b000, 2'd3, 2'd1, 2'd2);
    in_valid = 1'b1;
    chk("abort_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_valid", out_valid, 0);
      @(negedge clk);
    end
    send("r3chk", mk(3'b000, 2'd0, 2'd3, 2'd1));
    finish("r3chk", 4'h0, 2'd0, 1'b1, 1'b0);
    send("post", mk(3'b111, 2'd1, 2'd0, 2'd2));
    finish("post", 4'h2, 2'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
